cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Control FSM for the 2-way set-associative L1 cache.
- Sequences the cache datapath: way select for the 128-bit line word mux, per-way tag/data/valid/dirty array loads, LRU update, and write-back/allocate traffic to physical memory.
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and the pmem port. Write-back, write-allocate policy.

Parameters:
- CNT_W, 16, width of performance counters (used only with CACHE_PERF_CNT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  CPU request complete
- hit0, hit1  in  1 each  tag match and valid, way 0 / way 1
- valid0, valid1  in  1 each  valid bit of indexed set, per way
- dirty0, dirty1  in  1 each  dirty bit of indexed set, per way
- lru_out  in  1  LRU bit of indexed set; value is the victim way
- way_sel  out  1  way driving the output word mux and data writes
- load_data  out  2  per-way data array write enable
- load_tag  out  2  per-way tag array write enable
- load_valid  out  2  per-way valid write enable; valid_in is tied 1
- load_dirty  out  2  per-way dirty write enable
- dirty_in  out  1  dirty value written
- lru_load  out  1  LRU array write enable
- lru_in  out  1  new LRU value
- datain_sel  out  1  0 = CPU word merged into line; 1 = pmem line
- pmem_addr_sel  out  1  0 = CPU address (line-aligned); 1 = victim tag + set
- pmem_read  out  1  physical memory line read
- pmem_write  out  1  physical memory line write
- pmem_resp  in  1  pmem transaction done

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Type is a 2-bit enum.
- All outputs are combinational from the state and the inputs. Each output defaults to 0 in every state unless stated below.
- Reset: at the clk edge with reset=1, the state goes to IDLE. All outputs are then 0 with no request. Reset mid-WRITEBACK or mid-ALLOCATE aborts the transaction, and pmem strobes drop in the following cycle.

IDLE, no request:
- Stay in IDLE. A pmem_resp arriving here is ignored.

IDLE, request with hit (hit0|hit1):
- way_sel = hit1. mem_resp = 1 in the same cycle (0-cycle hit latency).
- lru_load = 1, lru_in = ~way_sel.
- For a write, additionally: load_data[way_sel] = 1, datain_sel = 0, load_dirty[way_sel] = 1, dirty_in = 1.
- Stay in IDLE.
- hit0 and hit1 both high is illegal. Way 0 wins, and the simulation assertion fires.

IDLE, request with miss:
- victim = lru_out.
- If valid[victim] & dirty[victim], go to WRITEBACK; otherwise go to ALLOCATE.
- mem_resp = 0.

WRITEBACK:
- pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
- Hold until pmem_resp, then go to ALLOCATE.

ALLOCATE:
- pmem_read = 1, pmem_addr_sel = 0, way_sel = victim.
- On pmem_resp: load_data[victim] = 1, datain_sel = 1, load_tag[victim] = 1, load_valid[victim] = 1, load_dirty[victim] = 1, dirty_in = 0. Go to IDLE.
- The request, still held by the CPU, then hits in the next cycle.

Latency and protocol:
- Miss latency = pmem latency (+ a second pmem latency if dirty) + 1 cycle.
- mem_read and mem_write both high is illegal (assertion). The CPU must not drop a request before mem_resp.
- The victim is latched on the IDLE-to-miss transition. Later lru_out changes do not move an in-flight miss.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, add outputs hit_count, miss_count and wb_count, each CNT_W wide. They reset to 0 and increment as follows:
  - hit_count: on each IDLE hit with mem_resp.
  - miss_count: on each IDLE-to-WRITEBACK or IDLE-to-ALLOCATE transition.
  - wb_count: on WRITEBACK completion.
- Counters saturate at all-ones.
- When undefined, the ports and logic are absent.

Decomposition:
- lc3b_types package: lc3b_word, lc3b_data (128-bit), and the new cache_ctrl_state_t enum.
- Sub-module: cache_perf_counter, one saturating CNT_W counter instantiated three times. It exists only under the macro.

Test Plan:
- Reset, then idle: all outputs 0. pmem_resp pulse -> no state change.
- Read, hit1=1, lru_out=1 -> same cycle: mem_resp=1, way_sel=1, lru_load=1, lru_in=0, load_data=2'b00.
- Write, hit0=1 -> mem_resp=1, load_data=2'b01, load_dirty=2'b01, dirty_in=1, datain_sel=0, lru_in=1.
- Read miss, lru_out=0, valid0=1, dirty0=1, pmem latency 3 -> WRITEBACK (pmem_write, addr_sel=1) for 3 cycles, then ALLOCATE (pmem_read) for 3 cycles, then line load into way 0 with dirty_in=0. The next cycle hits with mem_resp=1.
- Write miss, clean victim way 1 -> straight to ALLOCATE, load_tag=2'b10, then a write-hit cycle sets dirty.
- Reset asserted during ALLOCATE -> IDLE next edge, pmem_read=0. With CACHE_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the L1 cache slice.
//   lc3b_word          : 16-bit CPU word
//   lc3b_data          : 128-bit cache line
//   cache_ctrl_state_t : cache controller FSM state (2-bit enum)
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_ctrl_state_t;

endpackage

// File: rtl/cache_ctrl_perf_counter.sv
// cache_perf_counter: one saturating event counter.
// Only compiled when CACHE_PERF_CNT_EN is defined.
//   clk   : system clock
//   reset : synchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
`ifdef CACHE_PERF_CNT_EN
module cache_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/cache_ctrl.sv
// cache_ctrl: control FSM for the 2-way set-associative, write-back,
// write-allocate L1 cache. Drives the datapath array loads, LRU update,
// line word mux select and pmem write-back/allocate traffic.
//
// Optional feature macro: CACHE_PERF_CNT_EN adds hit/miss/write-back
// counters (hit_count, miss_count, wb_count, CNT_W bits each).
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_read, mem_write        : CPU request, held until mem_resp
//   mem_resp                   : CPU request complete
//   hit0/1, valid0/1, dirty0/1 : per-way status of the indexed set
//   lru_out                    : LRU bit of indexed set (= victim way)
//   way_sel                    : way for word mux and data writes
//   load_data/tag/valid/dirty  : per-way array write enables
//   dirty_in                   : dirty value written
//   lru_load, lru_in           : LRU write enable and value
//   datain_sel                 : 0 = CPU merged word, 1 = pmem line
//   pmem_addr_sel              : 0 = CPU line address, 1 = victim tag+set
//   pmem_read, pmem_write      : pmem line strobes
//   pmem_resp                  : pmem transaction done
//   fsm_state                  : current FSM state (observation only)
//
// Handshake: the CPU raises mem_read or mem_write and holds it until the
// cycle mem_resp is high; pmem_read/pmem_write are held until the cycle
// pmem_resp is high, which completes the transfer.
module cache_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    input  logic              hit0,
    input  logic              hit1,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              dirty0,
    input  logic              dirty1,
    input  logic              lru_out,
    output logic              way_sel,
    output logic [1:0]        load_data,
    output logic [1:0]        load_tag,
    output logic [1:0]        load_valid,
    output logic [1:0]        load_dirty,
    output logic              dirty_in,
    output logic              lru_load,
    output logic              lru_in,
    output logic              datain_sel,
    output logic              pmem_addr_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output cache_ctrl_state_t fsm_state
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
`endif
);

    cache_ctrl_state_t state, next_state;
    logic victim_q, victim_d;
    logic req, any_hit, hit_way, victim_dirty;

    assign req          = mem_read | mem_write;
    assign any_hit      = hit0 | hit1;
    // Way 0 wins if both hit (illegal, flagged by the assertion below).
    assign hit_way      = ~hit0;
    assign victim_dirty = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);
    assign fsm_state    = state;

    // Victim is captured when the miss is detected so that LRU updates
    // from elsewhere cannot retarget an in-flight miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state    <= next_state;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        next_state    = state;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        way_sel       = 1'b0;
        load_data     = 2'b00;
        load_tag      = 2'b00;
        load_valid    = 2'b00;
        load_dirty    = 2'b00;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        case (state)
            IDLE: begin
                if (req && any_hit) begin
                    way_sel  = hit_way;
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~hit_way;
                    if (mem_write) begin
                        load_data[hit_way]  = 1'b1;
                        load_dirty[hit_way] = 1'b1;
                        dirty_in            = 1'b1;
                        datain_sel          = 1'b0;
                    end
                end else if (req) begin
                    victim_d   = lru_out;
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    load_data[victim_q]  = 1'b1;
                    load_tag[victim_q]   = 1'b1;
                    load_valid[victim_q] = 1'b1;
                    load_dirty[victim_q] = 1'b1;
                    datain_sel           = 1'b1;
                    dirty_in             = 1'b0;
                    next_state           = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    a_single_hit: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE && req) |-> !(hit0 && hit1));
    a_single_op: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));

`ifdef CACHE_PERF_CNT_EN
    logic hit_evt, miss_evt, wb_evt;
    assign hit_evt  = (state == IDLE) && req && any_hit;
    assign miss_evt = (state == IDLE) && req && !any_hit;
    assign wb_evt   = (state == WRITEBACK) && pmem_resp;

    cache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk(clk), .reset(reset), .inc(hit_evt), .count(hit_count)
    );
    cache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk(clk), .reset(reset), .inc(miss_evt), .count(miss_count)
    );
    cache_perf_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk(clk), .reset(reset), .inc(wb_evt), .count(wb_count)
    );
`else
    wire unused_cnt_w = |CNT_W;
`endif

endmodule
